// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared state encoding and default sizing for the GCD scheduler
package gcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam int DEF_W       = 8;
    localparam int DEF_TIMEOUT = 1023;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick, searching upward from ptr with wrap
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic [N-1:0] upper;
    logic [N-1:0] pick;

    // Requests at or above ptr take priority; otherwise wrap to the lowest request.
    always_comb begin
        upper = '0;
        for (int i = 0; i < N; i++) begin
            upper[i] = req[i] && (i >= int'(ptr));
        end
        pick = (|upper) ? upper : req;
    end

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pick[i]) begin
                grant     = '0;
                grant[i]  = 1'b1;
                grant_idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/gcd_scheduler.sv
// rtl/gcd_scheduler.sv - round-robin sharing of one subtractive GCD engine among N_REQ requesters
module gcd_scheduler
    import gcd_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int W       = DEF_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    output logic [N_REQ-1:0]   rsp_valid,
    input  logic [N_REQ-1:0]   rsp_ready,
    output logic [W-1:0]       rsp_result,
    output logic               rsp_err,
    output logic               eng_start,
    output logic [W-1:0]       eng_a,
    output logic [W-1:0]       eng_b,
    input  logic               eng_done,
    input  logic [W-1:0]       eng_result,
    output logic               busy
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] WDOG_LIMIT = CW'(TIMEOUT);
    localparam logic [IW-1:0] LAST_REQ   = IW'(N_REQ - 1);

    state_t        state_q, state_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  result_q, result_d;
    logic          err_q, err_d;
    logic [CW-1:0] wdog_q, wdog_d;

    logic [N_REQ-1:0] grant;
    logic [IW-1:0]    grant_idx;
    logic [W-1:0]     a_sel, b_sel;
    logic             rsp_ack;

    rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                a_sel = req_a[i*W +: W];
                b_sel = req_b[i*W +: W];
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rsp_valid[i] = (state_q == ST_RESP) && (owner_q == IW'(i));
        end
    end

    assign rsp_ack    = |(rsp_valid & rsp_ready);
    assign req_ready  = (state_q == ST_IDLE) ? grant : '0;
    assign eng_start  = (state_q == ST_LOAD);
    assign eng_a      = a_q;
    assign eng_b      = b_q;
    assign rsp_result = result_q;
    assign rsp_err    = err_q && (state_q == ST_RESP);
    assign busy       = (state_q != ST_IDLE);

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        err_d    = err_q;
        wdog_d   = wdog_q;
        unique case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    owner_d = grant_idx;
                    // The subtractive engine never terminates on a zero operand.
                    if (a_sel == '0 || b_sel == '0) begin
                        result_d = a_sel | b_sel;
                        err_d    = 1'b0;
                        state_d  = ST_RESP;
                    end else begin
                        a_d     = a_sel;
                        b_d     = b_sel;
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                wdog_d  = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (wdog_q != WDOG_LIMIT) begin
                    wdog_d = wdog_q + CW'(1);
                end
                if (eng_done) begin
                    result_d = eng_result;
                    err_d    = 1'b0;
                    state_d  = ST_RESP;
                end else if (wdog_q == WDOG_LIMIT) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ack) begin
                    rr_ptr_d = (owner_q == LAST_REQ) ? '0 : owner_q + IW'(1);
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            wdog_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            err_q    <= err_d;
            wdog_q   <= wdog_d;
        end
    end

endmodule

// File: tb/tb_gcd_scheduler.sv
// tb/tb_gcd_scheduler.sv - directed scoreboard bench for gcd_scheduler with a behavioural engine
module tb_gcd_scheduler;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int TO = 15;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic [N-1:0]   rsp_valid;
    logic [N-1:0]   rsp_ready = '0;
    logic [W-1:0]   rsp_result;
    logic           rsp_err;
    logic           eng_start;
    logic [W-1:0]   eng_a, eng_b;
    logic           eng_done = 1'b0;
    logic [W-1:0]   eng_result;
    logic           busy;

    int errors = 0;
    int checks = 0;
    int starts = 0;

    int           eng_delay = 10;
    bit           eng_hang = 1'b0;
    int           eng_cnt = 0;
    bit           eng_run = 1'b0;
    logic [W-1:0] eng_res = '0;

    int           q_own[$];
    logic [W-1:0] q_res[$];
    logic         q_err[$];

    always #5 clk = ~clk;

    gcd_scheduler #(.N_REQ(N), .W(W), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .eng_start  (eng_start),
        .eng_a      (eng_a),
        .eng_b      (eng_b),
        .eng_done   (eng_done),
        .eng_result (eng_result),
        .busy       (busy)
    );

    function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Engine stand-in: done rises eng_delay cycles after start, never if eng_hang.
    always @(posedge clk) begin
        if (eng_start) begin
            eng_done <= 1'b0;
            eng_run  <= 1'b1;
            eng_cnt  <= eng_delay;
            eng_res  <= ref_gcd(eng_a, eng_b);
        end else if (eng_run && !eng_hang) begin
            if (eng_cnt <= 1) begin
                eng_done <= 1'b1;
                eng_run  <= 1'b0;
            end else begin
                eng_cnt <= eng_cnt - 1;
            end
        end
    end
    assign eng_result = eng_done ? eng_res : '0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (eng_start) starts++;
            chk("req_ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
            chk("rsp_valid_onehot", 32'($countones(rsp_valid) <= 1), 32'd1);
            chk("req_ready_only_idle", 32'(busy && (req_ready != '0)), 32'd0);
        end
    end

    task automatic push_exp(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
        q_own.push_back(idx);
        if (a == 0 || b == 0) begin
            q_res.push_back(a | b);
            q_err.push_back(1'b0);
        end else if (eng_hang) begin
            q_res.push_back('0);
            q_err.push_back(1'b1);
        end else begin
            q_res.push_back(ref_gcd(a, b));
            q_err.push_back(1'b0);
        end
    endtask

    task automatic send(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        n = 0;
        req_a[idx*W +: W] = a;
        req_b[idx*W +: W] = b;
        req_valid[idx] = 1'b1;
        #1;
        while (!req_ready[idx] && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("req_granted", 32'(req_ready[idx]), 32'd1);
        if (req_ready[idx]) push_exp(idx, a, b);
        @(negedge clk);
        req_valid[idx] = 1'b0;
    endtask

    task automatic recv(input int hold, output int lat);
        int           n;
        int           own;
        logic [W-1:0] er;
        logic         ee;
        logic [N-1:0] own_bit;
        n = 0;
        while (rsp_valid == '0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        lat = n;
        chk("rsp_arrived", 32'(rsp_valid != '0), 32'd1);
        own = 0;
        er = '0;
        ee = 1'b0;
        if (q_own.size() != 0) begin
            own = q_own.pop_front();
            er = q_res.pop_front();
            ee = q_err.pop_front();
        end
        own_bit = N'(1) << own;
        chk("rsp_valid_owner", 32'(rsp_valid), 32'(own_bit));
        chk("rsp_result", 32'(rsp_result), 32'(er));
        chk("rsp_err", 32'(rsp_err), 32'(ee));
        for (int h = 0; h < hold; h++) begin
            rsp_ready = ~own_bit;
            @(negedge clk);
            chk("hold_rsp_valid", 32'(rsp_valid), 32'(own_bit));
            chk("hold_rsp_result", 32'(rsp_result), 32'(er));
            chk("hold_req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = own_bit;
        @(negedge clk);
        rsp_ready = '0;
        chk("idle_after_rsp", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        int           lat;
        int           s0;
        logic [W-1:0] za [3];
        logic [W-1:0] zb [3];

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_result", 32'(rsp_result), 32'd0);
        chk("reset_rsp_err", 32'(rsp_err), 32'd0);
        chk("reset_eng_start", 32'(eng_start), 32'd0);
        chk("reset_eng_ab", 32'({eng_a, eng_b}), 32'd0);

        // single requester through the engine
        s0 = starts;
        send(0, 8'd48, 8'd18);
        chk("load_eng_start", 32'(eng_start), 32'd1);
        chk("load_eng_a", 32'(eng_a), 32'd48);
        chk("load_eng_b", 32'(eng_b), 32'd18);
        recv(0, lat);
        chk("single_start_pulse", 32'(starts - s0), 32'd1);

        // two requesters valid from reset: 0 then 2
        rst_n = 1'b0;
        req_a[0*W +: W] = 8'd12; req_b[0*W +: W] = 8'd8;
        req_a[2*W +: W] = 8'd35; req_b[2*W +: W] = 8'd14;
        req_valid = 4'b0101;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rr_first_grant", 32'(req_ready), 32'b0001);
        push_exp(0, 8'd12, 8'd8);
        @(negedge clk);
        req_valid[0] = 1'b0;
        recv(0, lat);
        #1;
        chk("rr_second_grant", 32'(req_ready), 32'b0100);
        push_exp(2, 8'd35, 8'd14);
        @(negedge clk);
        req_valid[2] = 1'b0;
        recv(0, lat);
        req_valid = 4'b1001;
        #1;
        chk("rr_ptr_after_2", 32'(req_ready), 32'b1000);
        req_valid = '0;
        @(negedge clk);

        // zero operands bypass the engine
        za[0] = 8'd0; zb[0] = 8'd25;
        za[1] = 8'd9; zb[1] = 8'd0;
        za[2] = 8'd0; zb[2] = 8'd0;
        s0 = starts;
        for (int k = 0; k < 3; k++) begin
            send(1, za[k], zb[k]);
            recv(0, lat);
            chk("zero_rsp_next_cycle", 32'(lat), 32'd0);
        end
        chk("zero_no_eng_start", 32'(starts - s0), 32'd0);

        // hung engine: TIMEOUT+1 WAIT cycles, then error response
        eng_hang = 1'b1;
        s0 = starts;
        send(2, 8'd40, 8'd15);
        recv(0, lat);
        chk("timeout_wait_cycles", 32'(lat - 1), 32'(TO + 1));
        chk("timeout_one_start", 32'(starts - s0), 32'd1);
        eng_hang = 1'b0;
        eng_delay = 4;
        send(3, 8'd21, 8'd14);
        recv(0, lat);

        // response back-pressure with a competing request pending
        send(3, 8'd27, 8'd36);
        req_a[0*W +: W] = 8'd5;
        req_b[0*W +: W] = 8'd10;
        req_valid[0] = 1'b1;
        recv(20, lat);
        req_valid = '0;
        @(negedge clk);

        // reset mid-WAIT drops the request
        eng_delay = 30;
        send(1, 8'd100, 8'd75);
        repeat (5) @(negedge clk);
        chk("pre_reset_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midwait_reset_busy", 32'(busy), 32'd0);
        chk("midwait_reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midwait_reset_rsp", 32'({rsp_result, rsp_err}), 32'd0);
        chk("midwait_reset_eng", 32'({eng_start, eng_a, eng_b}), 32'd0);
        chk("midwait_reset_req_ready", 32'(req_ready), 32'd0);
        q_own.delete();
        q_res.delete();
        q_err.delete();
        rst_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            chk("no_rsp_for_dropped", 32'(rsp_valid), 32'd0);
        end
        eng_delay = 5;
        send(0, 8'd14, 8'd49);
        recv(0, lat);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gcd_scheduler.md
Name: gcd_scheduler

Overview:
- Shares one subtractive GCD engine (controller plus datapath pair) among N_REQ requesters.
- Round-robin arbitration picks one requester at a time.
- The selected operands are loaded into the engine with a one-cycle start pulse, and the scheduler waits for done.
- The result is routed back to the owning requester through a valid/ready response handshake.
- Zero operands are short-circuited without using the engine, because the subtractive engine never terminates on zero. A watchdog turns a hung engine into an error response.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- W, 8, operand/result width in bits.
- TIMEOUT, 1023, maximum cycles allowed in WAIT before an error response.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester accept; at most one bit high.
- req_a  in  N_REQ*W  operand A, requester i at bits [i*W +: W].
- req_b  in  N_REQ*W  operand B, same packing as req_a.
- rsp_valid  out  N_REQ  response valid; only the owning requester's bit is ever high.
- rsp_ready  in  N_REQ  per-requester response accept.
- rsp_result  out  W  GCD result, shared by all requesters.
- rsp_err  out  1  high with rsp_valid when the watchdog expired.
- eng_start  out  1  one-cycle start pulse to the engine.
- eng_a  out  W  registered operand A to the engine.
- eng_b  out  W  registered operand B to the engine.
- eng_done  in  1  engine done level.
- eng_result  in  W  engine result, valid while eng_done is high.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, rr_ptr=0, and all outputs 0 (req_ready, rsp_valid, rsp_result, rsp_err, eng_start, eng_a, eng_b, busy). Reset overrides any state, including mid-WAIT or RESP; an in-flight request is dropped with no response.
- FSM states: IDLE, LOAD, WAIT, RESP.
- IDLE:
  - Grant is combinational round-robin: the first i with req_valid[i]=1, searching from rr_ptr upward and wrapping.
  - req_ready[grant]=1 only in IDLE; handshake when req_valid & req_ready.
  - On handshake, latch owner=grant, a, b.
  - If a==0 or b==0: result=a|b (gcd(0,0)=0), err=0, go to RESP directly; the engine is not touched.
  - Otherwise go to LOAD.
- LOAD: eng_a/eng_b hold the latched operands; eng_start=1 for exactly this cycle; clear the watchdog; go to WAIT.
- WAIT:
  - Watchdog increments each cycle.
  - eng_done=1: latch result=eng_result, err=0, go to RESP.
  - Else if watchdog==TIMEOUT: result=0, err=1, go to RESP.
  - If eng_done and timeout coincide, done wins (err=0).
- RESP:
  - rsp_valid[owner]=1; rsp_result and rsp_err are held stable until rsp_ready[owner]=1.
  - On that handshake: rr_ptr=(owner+1) mod N_REQ, go to IDLE.
  - rsp_ready bits of other requesters are ignored.
- Latency, request handshake to rsp_valid:
  - Nonzero operands: 2 + engine cycles.
  - Zero operand: 1 cycle.
- The next request can be accepted in the cycle after the response handshake.
- A requester may drop req_valid before it is granted; no state change results.
- eng_a and eng_b remain stable from LOAD through WAIT.
- Watchdog counter width is clog2(TIMEOUT+1), and the counter saturates.

Decomposition:
- Package gcd_pkg holds:
  - the state encoding enum (IDLE, LOAD, WAIT, RESP);
  - the default operand width constant;
  - the default TIMEOUT constant.
- One sub-module, rr_arbiter: parameter N, inputs req[N] and ptr, output one-hot grant[N] plus grant index. It is purely combinational and instantiated once.
- The FSM, operand registers, watchdog and response mux stay in gcd_scheduler.

Test Plan:
- Single requester 0 sends a=48, b=18; engine model returns 6 after 10 cycles -> eng_start pulses once with eng_a=48, eng_b=18; rsp_valid[0]=1, rsp_result=6, rsp_err=0; busy low after the response handshake.
- Requesters 0 and 2 both valid from reset with (12,8) and (35,14) -> requester 0 served first (result 4), then requester 2 (result 7); rr_ptr=3 afterwards; only one req_ready bit is ever high.
- Requester 1 sends (0,25), then (9,0), then (0,0) -> results 25, 9, 0, each with rsp_valid one cycle after the handshake; eng_start never asserted.
- Engine model never raises done with TIMEOUT=15 -> rsp_err=1 and rsp_result=0 exactly 16 cycles after LOAD; the next request is still served normally.
- rsp_ready[3] held low for 20 cycles while a response for requester 3 is pending -> rsp_valid[3] and rsp_result stable throughout; no new req_ready asserted.
- rst_n driven low for one cycle mid-WAIT -> the next cycle has state IDLE and all outputs 0; no response issued for the dropped request; a new request completes correctly.
